// File: rtl/decode_issue_stage.sv
// RV32I/RV64I decode and issue stage: decodes the instruction in decode, resolves RAW hazards
// against EXE/MEM/WB by stalling or forwarding, and registers one instruction per cycle into EXE.
module decode_issue_stage #(
    parameter int XLEN      = 64,
    parameter bit BYPASS_EN = 1'b1,
    parameter bit BR_STALL  = 1'b1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            DE_V,
    input  logic [31:0]     DE_IR,
    input  logic [XLEN-1:0] DE_NPC,
    output logic            DE_READY,
    output logic [4:0]      RF_RS1_ADDR,
    output logic [4:0]      RF_RS2_ADDR,
    input  logic [XLEN-1:0] RF_RS1_DATA,
    input  logic [XLEN-1:0] RF_RS2_DATA,
    input  logic [4:0]      EXE_DR,
    input  logic [4:0]      MEM_DR,
    input  logic [4:0]      WB_DR,
    input  logic            EXE_DR_V,
    input  logic            MEM_DR_V,
    input  logic            WB_DR_V,
    input  logic            EXE_IS_LOAD,
    input  logic [XLEN-1:0] EXE_RES,
    input  logic [XLEN-1:0] MEM_RES,
    input  logic [XLEN-1:0] WB_RES,
    input  logic            EXE_READY,
    input  logic            FLUSH,
    output logic            EXE_V,
    output logic [31:0]     EXE_IR,
    output logic [XLEN-1:0] EXE_NPC,
    output logic [XLEN-1:0] ALU1,
    output logic [XLEN-1:0] ALU2,
    output logic [XLEN-1:0] EXE_RS2_VAL,
    output logic [XLEN-1:0] TARGET_ADDRESS,
    output logic            EXE_ILLEGAL,
    output logic            V_DE_FE_BR_STALL
);

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [31:0] NOP_IR       = 32'h0000_0013;
    localparam bit IS_RV64               = (XLEN == 64);

    typedef enum logic [2:0] {FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    fmt_e            fmt;
    logic            illegal;
    logic            rs1_used;
    logic            rs2_used;
    logic [2:0]      hit1;
    logic [2:0]      hit2;
    logic            haz_raw;
    logic            haz_load;
    logic            stall;
    logic            accept;
    logic            load_payload;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] jalr_sum;

    logic            exe_v_d, exe_v_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] npc_q;
    logic [XLEN-1:0] alu1_d, alu1_q;
    logic [XLEN-1:0] alu2_d, alu2_q;
    logic [XLEN-1:0] rs2v_d, rs2v_q;
    logic [XLEN-1:0] tgt_d, tgt_q;
    logic            ill_q;

    assign opcode      = DE_IR[6:0];
    assign rs1         = DE_IR[19:15];
    assign rs2         = DE_IR[24:20];
    assign RF_RS1_ADDR = rs1;
    assign RF_RS2_ADDR = rs2;

    always_comb begin
        // NOTE: default assigned first so no opcode path leaves fmt unassigned (no latch).
        fmt = FMT_NONE;
        case (opcode)
            OPC_OP:                                        fmt = FMT_R;
            OPC_OP_32:     if (IS_RV64)                    fmt = FMT_R;
            OPC_LOAD, OPC_OP_IMM, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM:                      fmt = FMT_I;
            OPC_OP_IMM_32: if (IS_RV64)                    fmt = FMT_I;
            OPC_STORE:                                     fmt = FMT_S;
            OPC_BRANCH:                                    fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                            fmt = FMT_U;
            OPC_JAL:                                       fmt = FMT_J;
            default:                                       fmt = FMT_NONE;
        endcase
    end

    assign illegal  = (fmt == FMT_NONE);
    assign rs1_used = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    assign rs2_used = fmt inside {FMT_R, FMT_S, FMT_B};

    // Match vectors are ordered {WB, MEM, EXE}; x0 never matches any stage.
    assign hit1[0] = (rs1 != 5'd0) && EXE_DR_V && (EXE_DR == rs1);
    assign hit1[1] = (rs1 != 5'd0) && MEM_DR_V && (MEM_DR == rs1);
    assign hit1[2] = (rs1 != 5'd0) && WB_DR_V  && (WB_DR  == rs1);
    assign hit2[0] = (rs2 != 5'd0) && EXE_DR_V && (EXE_DR == rs2);
    assign hit2[1] = (rs2 != 5'd0) && MEM_DR_V && (MEM_DR == rs2);
    assign hit2[2] = (rs2 != 5'd0) && WB_DR_V  && (WB_DR  == rs2);

    assign haz_raw  = (rs1_used && (|hit1)) || (rs2_used && (|hit2));
    assign haz_load = EXE_IS_LOAD && ((rs1_used && hit1[0]) || (rs2_used && hit2[0]));
    assign stall    = BYPASS_EN ? haz_load : haz_raw;

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [2:0]      hit,
        input logic [XLEN-1:0] rf_data,
        input logic [XLEN-1:0] exe_res,
        input logic [XLEN-1:0] mem_res,
        input logic [XLEN-1:0] wb_res
    );
        if (hit[0])      return exe_res;
        else if (hit[1]) return mem_res;
        else if (hit[2]) return wb_res;
        return rf_data;
    endfunction

    // Without bypassing any used match stalls, so the register file value is always current.
    assign rs1_val = BYPASS_EN ? fwd_sel(hit1, RF_RS1_DATA, EXE_RES, MEM_RES, WB_RES) : RF_RS1_DATA;
    assign rs2_val = BYPASS_EN ? fwd_sel(hit2, RF_RS2_DATA, EXE_RES, MEM_RES, WB_RES) : RF_RS2_DATA;

    assign imm_i    = XLEN'($signed(DE_IR[31:20]));
    assign imm_s    = XLEN'($signed({DE_IR[31:25], DE_IR[11:7]}));
    assign imm_b    = XLEN'($signed({DE_IR[31], DE_IR[7], DE_IR[30:25], DE_IR[11:8], 1'b0}));
    assign imm_u    = XLEN'($signed({DE_IR[31:12], 12'h000}));
    assign imm_j    = XLEN'($signed({DE_IR[31], DE_IR[19:12], DE_IR[20], DE_IR[30:21], 1'b0}));
    assign jalr_sum = rs1_val + imm_i;

    always_comb begin
        alu1_d = '0;
        alu2_d = '0;
        rs2v_d = '0;
        tgt_d  = '0;
        if (!illegal) begin
            case (opcode)
                OPC_LUI: alu1_d = imm_u;
                OPC_AUIPC: begin
                    alu1_d = DE_NPC;
                    alu2_d = imm_u;
                end
                OPC_JAL: begin
                    alu1_d = DE_NPC;
                    alu2_d = XLEN'(4);
                    tgt_d  = DE_NPC + imm_j;
                end
                OPC_JALR: begin
                    alu1_d = rs1_val;
                    alu2_d = imm_i;
                    tgt_d  = jalr_sum & ~XLEN'(1);
                end
                OPC_STORE: begin
                    alu1_d = rs1_val;
                    alu2_d = imm_s;
                    rs2v_d = rs2_val;
                end
                OPC_BRANCH: begin
                    alu1_d = rs1_val;
                    alu2_d = rs2_val;
                    rs2v_d = rs2_val;
                    tgt_d  = DE_NPC + imm_b;
                end
                OPC_OP, OPC_OP_32: begin
                    alu1_d = rs1_val;
                    alu2_d = rs2_val;
                    rs2v_d = rs2_val;
                end
                // Remaining legal opcodes are all I-type: loads, OP-IMM(-32), FENCE, SYSTEM.
                default: begin
                    alu1_d = rs1_val;
                    alu2_d = imm_i;
                end
            endcase
        end
    end

    assign DE_READY     = !stall && (!exe_v_q || EXE_READY);
    assign accept       = DE_V && DE_READY;
    assign load_payload = accept && !FLUSH;

    always_comb begin
        exe_v_d = exe_v_q;
        if (FLUSH)                      exe_v_d = 1'b0;
        else if (EXE_READY || !exe_v_q) exe_v_d = accept;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            exe_v_q <= 1'b0;
            ir_q    <= NOP_IR;
            npc_q   <= '0;
            alu1_q  <= '0;
            alu2_q  <= '0;
            rs2v_q  <= '0;
            tgt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            exe_v_q <= exe_v_d;
            if (load_payload) begin
                ir_q   <= DE_IR;
                npc_q  <= DE_NPC;
                alu1_q <= alu1_d;
                alu2_q <= alu2_d;
                rs2v_q <= rs2v_d;
                tgt_q  <= tgt_d;
                ill_q  <= illegal;
            end
        end
    end

    assign EXE_V          = exe_v_q;
    assign EXE_IR         = ir_q;
    assign EXE_NPC        = npc_q;
    assign ALU1           = alu1_q;
    assign ALU2           = alu2_q;
    assign EXE_RS2_VAL    = rs2v_q;
    assign TARGET_ADDRESS = tgt_q;
    assign EXE_ILLEGAL    = ill_q;

    assign V_DE_FE_BR_STALL = BR_STALL && DE_V &&
                              (opcode[6:2] inside {5'b11000, 5'b11001, 5'b11011});

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios, then randomized traffic against a
// behavioural model of decode, forwarding and the EXE handshake.
module tb_decode_issue_stage;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] I_ADD     = 32'h0020_81B3;  // add  x3,x1,x2
    localparam logic [31:0] I_ADDI65  = 32'h0012_8313;  // addi x6,x5,1
    localparam logic [31:0] I_LUI     = 32'h1234_53B7;  // lui  x7,0x12345
    localparam logic [31:0] I_BEQ     = 32'hFE00_0CE3;  // beq  x0,x0,-8
    localparam logic [31:0] I_ADDIW   = 32'h0050_009B;  // addiw x1,x0,5
    localparam logic [31:0] I_ADDI10  = 32'h0030_0093;  // addi x1,x0,3
    localparam logic [6:0]  OPCS [16] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0011011,
                                          7'b0110011, 7'b0111011, 7'b0110111, 7'b0010111,
                                          7'b1101111, 7'b1100111, 7'b1100011, 7'b0001111,
                                          7'b1110011, 7'b1111111, 7'b0000000, 7'b0101011};

    typedef struct packed {
        logic [63:0] alu1;
        logic [63:0] alu2;
        logic [63:0] rs2v;
        logic [63:0] tgt;
        logic        ill;
    } exp_t;

    logic        CLK, RESET_N, clk_en;
    logic        de_v, exe_dr_v, mem_dr_v, wb_dr_v, exe_is_load, exe_ready, flush;
    logic [31:0] de_ir;
    logic [63:0] de_npc, exe_res, mem_res, wb_res, rf1, rf2;
    logic [4:0]  exe_dr, mem_dr, wb_dr;
    logic [63:0] rf [32];

    logic        de_ready, exe_v, illegal, br_stall;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] exe_ir;
    logic [63:0] exe_npc, alu1, alu2, rs2_val, target;

    logic        s_de_ready, s_exe_v, s_illegal, s_br_stall;
    logic [4:0]  s_rs1_addr, s_rs2_addr;
    logic [31:0] s_exe_ir, s_exe_npc, s_alu1, s_alu2, s_rs2_val, s_target;

    logic        n_de_ready, n_exe_v, n_illegal, n_br_stall;
    logic [4:0]  n_rs1_addr, n_rs2_addr;
    logic [31:0] n_exe_ir;
    logic [63:0] n_exe_npc, n_alu1, n_alu2, n_rs2_val, n_target;

    int checks = 0;
    int errors = 0;

    assign rf1 = rf[rs1_addr];
    assign rf2 = rf[rs2_addr];

    decode_issue_stage #(.XLEN(64), .BYPASS_EN(1'b1), .BR_STALL(1'b1)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .DE_V(de_v), .DE_IR(de_ir), .DE_NPC(de_npc),
        .DE_READY(de_ready), .RF_RS1_ADDR(rs1_addr), .RF_RS2_ADDR(rs2_addr),
        .RF_RS1_DATA(rf1), .RF_RS2_DATA(rf2),
        .EXE_DR(exe_dr), .MEM_DR(mem_dr), .WB_DR(wb_dr),
        .EXE_DR_V(exe_dr_v), .MEM_DR_V(mem_dr_v), .WB_DR_V(wb_dr_v), .EXE_IS_LOAD(exe_is_load),
        .EXE_RES(exe_res), .MEM_RES(mem_res), .WB_RES(wb_res),
        .EXE_READY(exe_ready), .FLUSH(flush),
        .EXE_V(exe_v), .EXE_IR(exe_ir), .EXE_NPC(exe_npc), .ALU1(alu1), .ALU2(alu2),
        .EXE_RS2_VAL(rs2_val), .TARGET_ADDRESS(target), .EXE_ILLEGAL(illegal),
        .V_DE_FE_BR_STALL(br_stall)
    );

    decode_issue_stage #(.XLEN(32), .BYPASS_EN(1'b1), .BR_STALL(1'b1)) u_dut32 (
        .CLK(CLK), .RESET_N(RESET_N), .DE_V(de_v), .DE_IR(de_ir), .DE_NPC(de_npc[31:0]),
        .DE_READY(s_de_ready), .RF_RS1_ADDR(s_rs1_addr), .RF_RS2_ADDR(s_rs2_addr),
        .RF_RS1_DATA(rf1[31:0]), .RF_RS2_DATA(rf2[31:0]),
        .EXE_DR(exe_dr), .MEM_DR(mem_dr), .WB_DR(wb_dr),
        .EXE_DR_V(exe_dr_v), .MEM_DR_V(mem_dr_v), .WB_DR_V(wb_dr_v), .EXE_IS_LOAD(exe_is_load),
        .EXE_RES(exe_res[31:0]), .MEM_RES(mem_res[31:0]), .WB_RES(wb_res[31:0]),
        .EXE_READY(exe_ready), .FLUSH(flush),
        .EXE_V(s_exe_v), .EXE_IR(s_exe_ir), .EXE_NPC(s_exe_npc), .ALU1(s_alu1), .ALU2(s_alu2),
        .EXE_RS2_VAL(s_rs2_val), .TARGET_ADDRESS(s_target), .EXE_ILLEGAL(s_illegal),
        .V_DE_FE_BR_STALL(s_br_stall)
    );

    decode_issue_stage #(.XLEN(64), .BYPASS_EN(1'b0), .BR_STALL(1'b1)) u_dut_nb (
        .CLK(CLK), .RESET_N(RESET_N), .DE_V(de_v), .DE_IR(de_ir), .DE_NPC(de_npc),
        .DE_READY(n_de_ready), .RF_RS1_ADDR(n_rs1_addr), .RF_RS2_ADDR(n_rs2_addr),
        .RF_RS1_DATA(rf1), .RF_RS2_DATA(rf2),
        .EXE_DR(exe_dr), .MEM_DR(mem_dr), .WB_DR(wb_dr),
        .EXE_DR_V(exe_dr_v), .MEM_DR_V(mem_dr_v), .WB_DR_V(wb_dr_v), .EXE_IS_LOAD(exe_is_load),
        .EXE_RES(exe_res), .MEM_RES(mem_res), .WB_RES(wb_res),
        .EXE_READY(exe_ready), .FLUSH(flush),
        .EXE_V(n_exe_v), .EXE_IR(n_exe_ir), .EXE_NPC(n_exe_npc), .ALU1(n_alu1), .ALU2(n_alu2),
        .EXE_RS2_VAL(n_rs2_val), .TARGET_ADDRESS(n_target), .EXE_ILLEGAL(n_illegal),
        .V_DE_FE_BR_STALL(n_br_stall)
    );

    always begin
        #5;
        if (clk_en) CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Format class for RV64: 0 unknown, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J.
    function automatic int fmt_of(input logic [6:0] opc);
        case (opc)
            7'b0110011, 7'b0111011:                         return 1;
            7'b0000011, 7'b0010011, 7'b0011011,
            7'b1100111, 7'b0001111, 7'b1110011:             return 2;
            7'b0100011:                                     return 3;
            7'b1100011:                                     return 4;
            7'b0110111, 7'b0010111:                         return 5;
            7'b1101111:                                     return 6;
            default:                                        return 0;
        endcase
    endfunction

    function automatic logic [63:0] operand(input logic [4:0] r);
        if (r == 5'd0)                         return rf[0];
        if (exe_dr_v && exe_dr == r)           return exe_res;
        if (mem_dr_v && mem_dr == r)           return mem_res;
        if (wb_dr_v && wb_dr == r)             return wb_res;
        return rf[r];
    endfunction

    function automatic bit model_stall(input logic [31:0] ir);
        int f   = fmt_of(ir[6:0]);
        bit u1  = (f >= 1 && f <= 4);
        bit u2  = (f == 1 || f == 3 || f == 4);
        return exe_dr_v && exe_is_load && exe_dr != 5'd0 &&
               ((u1 && ir[19:15] == exe_dr) || (u2 && ir[24:20] == exe_dr));
    endfunction

    function automatic exp_t model_issue(input logic [31:0] ir, input logic [63:0] npc);
        exp_t        e;
        longint      sir   = longint'($signed(ir));
        longint      imm_i = sir >>> 20;
        longint      imm_s = ((sir >>> 25) <<< 5) | longint'(ir[11:7]);
        longint      imm_b = ((sir >>> 31) <<< 12) | (longint'(ir[7]) <<< 11) |
                             (longint'(ir[30:25]) <<< 5) | (longint'(ir[11:8]) <<< 1);
        longint      imm_u = (sir >>> 12) <<< 12;
        longint      imm_j = ((sir >>> 31) <<< 20) | (longint'(ir[19:12]) <<< 12) |
                             (longint'(ir[20]) <<< 11) | (longint'(ir[30:21]) <<< 1);
        logic [63:0] a     = operand(ir[19:15]);
        logic [63:0] b     = operand(ir[24:20]);
        e     = '0;
        e.ill = (fmt_of(ir[6:0]) == 0);
        if (!e.ill) begin
            case (ir[6:0])
                7'b0110111: e.alu1 = imm_u;
                7'b0010111: begin e.alu1 = npc; e.alu2 = imm_u; end
                7'b1101111: begin e.alu1 = npc; e.alu2 = 64'd4; e.tgt = npc + imm_j; end
                7'b1100111: begin e.alu1 = a; e.alu2 = imm_i; e.tgt = (a + imm_i) & ~64'd1; end
                7'b0100011: begin e.alu1 = a; e.alu2 = imm_s; e.rs2v = b; end
                7'b1100011: begin e.alu1 = a; e.alu2 = b; e.rs2v = b; e.tgt = npc + imm_b; end
                7'b0110011, 7'b0111011: begin e.alu1 = a; e.alu2 = b; e.rs2v = b; end
                default: begin e.alu1 = a; e.alu2 = imm_i; end
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ir = $urandom;
        ir[6:0] = OPCS[$urandom_range(0, 15)];
        if ($urandom_range(0, 3) != 0) begin
            ir[19:15] = 5'($urandom_range(0, 7));
            ir[24:20] = 5'($urandom_range(0, 7));
        end
        return ir;
    endfunction

    initial begin
        bit          ev, hold, acc, rdy_e;
        logic [31:0] e_ir;
        logic [63:0] e_npc;
        exp_t        e_pay;

        CLK = 1'b0; clk_en = 1'b0; RESET_N = 1'b1;
        de_v = 1'b0; de_ir = NOP; de_npc = '0;
        exe_dr = '0; mem_dr = '0; wb_dr = '0;
        exe_dr_v = 1'b0; mem_dr_v = 1'b0; wb_dr_v = 1'b0; exe_is_load = 1'b0;
        exe_res = '0; mem_res = '0; wb_res = '0; exe_ready = 1'b1; flush = 1'b0;
        rf[0] = '0;
        for (int i = 1; i < 32; i++) rf[i] = {$urandom, $urandom};

        // Reset with the clock idle
        #10 RESET_N = 1'b0;
        #1;
        check("rst_exe_v", exe_v, 0);
        check("rst_exe_ir", exe_ir, NOP);
        check("rst_alu1", alu1, 0);
        check("rst_target", target, 0);
        check("rst_illegal", illegal, 0);
        clk_en = 1'b1;
        @(negedge CLK); @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("post_rst_exe_v", exe_v, 0);

        // Forwarding from MEM and WB
        de_ir = I_ADD; de_npc = 64'h100; de_v = 1'b1;
        mem_dr = 5'd1; mem_dr_v = 1'b1; mem_res = 64'h55;
        wb_dr = 5'd2;  wb_dr_v = 1'b1;  wb_res = 64'h7;
        #1;
        check("fwd_de_ready", de_ready, 1);
        check("fwd_nobypass_stall", n_de_ready, 0);
        step();
        check("fwd_exe_v", exe_v, 1);
        check("fwd_exe_ir", exe_ir, I_ADD);
        check("fwd_alu1", alu1, 64'h55);
        check("fwd_alu2", alu2, 64'h7);
        check("fwd_alu1_x32", s_alu1, 32'h55);
        de_v = 1'b0; mem_dr_v = 1'b0; wb_dr_v = 1'b0;
        step();
        check("idle_exe_v", exe_v, 0);

        // Load-use stall, then forward from EXE
        exe_dr = 5'd5; exe_dr_v = 1'b1; exe_is_load = 1'b1; exe_res = 64'h1234;
        de_ir = I_ADDI65; de_npc = 64'h104; de_v = 1'b1;
        #1;
        check("lu_de_ready", de_ready, 0);
        step();
        check("lu_exe_v", exe_v, 0);
        exe_is_load = 1'b0;
        #1;
        check("lu_release_ready", de_ready, 1);
        step();
        check("lu_exe_v_after", exe_v, 1);
        check("lu_alu1", alu1, 64'h1234);
        check("lu_alu2", alu2, 64'h1);

        // Backpressure: outputs hold for three cycles
        exe_dr_v = 1'b0; exe_ready = 1'b0;
        de_ir = I_LUI; de_npc = 64'h2000; de_v = 1'b1;
        #1;
        check("bp_de_ready", de_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_exe_v", exe_v, 1);
            check("bp_exe_ir", exe_ir, I_ADDI65);
            check("bp_alu1", alu1, 64'h1234);
            check("bp_alu2", alu2, 64'h1);
            check("bp_npc", exe_npc, 64'h104);
            check("bp_de_ready_hold", de_ready, 0);
        end
        exe_ready = 1'b1;
        #1;
        check("bp_release_ready", de_ready, 1);
        step();
        check("bp_next_ir", exe_ir, I_LUI);
        check("bp_next_alu1", alu1, 64'h1234_5000);
        check("bp_next_alu2", alu2, 0);
        check("bp_next_npc", exe_npc, 64'h2000);

        // Branch target and fetch stall
        de_ir = I_BEQ; de_npc = 64'h1000; de_v = 1'b1;
        #1;
        check("br_stall_on", br_stall, 1);
        step();
        check("br_exe_v", exe_v, 1);
        check("br_target", target, 64'hFF8);
        de_v = 1'b0;
        #1;
        check("br_stall_off", br_stall, 0);

        // Flush together with accept
        de_ir = I_ADDI65; de_v = 1'b1; flush = 1'b1;
        #1;
        check("flush_de_ready", de_ready, 1);
        step();
        check("flush_exe_v", exe_v, 0);
        flush = 1'b0;

        // ADDIW is illegal only on the 32-bit build
        de_ir = I_ADDIW; de_npc = 64'h3000;
        step();
        check("addiw64_illegal", illegal, 0);
        check("addiw64_alu2", alu2, 64'd5);
        check("addiw32_exe_v", s_exe_v, 1);
        check("addiw32_illegal", s_illegal, 1);
        check("addiw32_alu1", s_alu1, 0);
        check("addiw32_alu2", s_alu2, 0);

        // x0 source never matches a stage writing x0
        exe_dr = 5'd0; exe_dr_v = 1'b1; exe_is_load = 1'b1; exe_res = 64'hDEAD;
        de_ir = I_ADDI10;
        #1;
        check("x0_de_ready", de_ready, 1);
        check("x0_nobypass_ready", n_de_ready, 1);
        step();
        check("x0_exe_v", exe_v, 1);
        check("x0_alu1", alu1, 0);
        check("x0_alu2", alu2, 64'd3);

        // Asynchronous reset in the middle of a stall
        exe_dr_v = 1'b0; exe_is_load = 1'b0; exe_ready = 1'b0; de_ir = I_LUI;
        step();
        check("mid_exe_v", exe_v, 1);
        check("mid_de_ready", de_ready, 0);
        #2 RESET_N = 1'b0;
        #1;
        check("mid_rst_exe_v", exe_v, 0);
        check("mid_rst_exe_ir", exe_ir, NOP);
        de_v = 1'b0; exe_ready = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b1;

        // Randomized traffic against the model
        ev = 1'b0; hold = 1'b0; e_ir = NOP; e_npc = '0; e_pay = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge CLK);
            check("rnd_exe_v", exe_v, ev);
            if (ev) begin
                check("rnd_exe_ir", exe_ir, e_ir);
                check("rnd_exe_npc", exe_npc, e_npc);
                check("rnd_alu1", alu1, e_pay.alu1);
                check("rnd_alu2", alu2, e_pay.alu2);
                check("rnd_rs2_val", rs2_val, e_pay.rs2v);
                check("rnd_target", target, e_pay.tgt);
                check("rnd_illegal", illegal, e_pay.ill);
            end
            exe_dr = 5'($urandom_range(0, 7)); mem_dr = 5'($urandom_range(0, 7));
            wb_dr = 5'($urandom_range(0, 7));
            exe_dr_v = $urandom_range(0, 1) == 1; mem_dr_v = $urandom_range(0, 1) == 1;
            wb_dr_v = $urandom_range(0, 1) == 1;
            exe_is_load = $urandom_range(0, 2) == 0;
            exe_res = {$urandom, $urandom}; mem_res = {$urandom, $urandom};
            wb_res = {$urandom, $urandom};
            exe_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 9) == 0;
            if (!hold) begin
                de_v = $urandom_range(0, 4) != 0;
                de_ir = rand_instr();
                de_npc = {$urandom, $urandom};
            end
            #1;
            rdy_e = !model_stall(de_ir) && (!ev || exe_ready);
            check("rnd_de_ready", de_ready, rdy_e);
            check("rnd_br_stall", br_stall,
                  de_v && (de_ir[6:2] inside {5'b11000, 5'b11001, 5'b11011}));
            acc = de_v && rdy_e;
            if (flush) ev = 1'b0;
            else if (exe_ready || !ev) begin
                ev = acc;
                if (acc) begin
                    e_ir = de_ir;
                    e_npc = de_npc;
                    e_pay = model_issue(de_ir, de_npc);
                end
            end
            hold = de_v && !acc;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
